// File: rtl/mul16_seq_if.sv
// mul16_seq_if: bus between the sequential multiplier and its environment.
//   start/a/b      : multiply request and operands
//   busy/done/p    : status and 32-bit product
//   add_a/add_b    : operands presented to the external ripple-carry adder
//   add_s/add_co   : combinational sum and carry-out returned by that adder
// master: environment side (requester plus external adder)
// slave : the multiplier
interface mul16_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_s;
  logic               add_co;

  modport master (
    output start, a, b, add_s, add_co,
    input  busy, done, p, add_a, add_b
  );

  modport slave (
    input  start, a, b, add_s, add_co,
    output busy, done, p, add_a, add_b
  );
endinterface

// File: rtl/mul16_seq.sv
// mul16_seq: sequential 16x16 unsigned shift-and-add multiplier.
// Uses an external 16-bit adder through the add_* signals of the bus.
//   clk : rising-edge clock
//   rst : synchronous reset, active-high
//   bus : mul16_seq_if.slave
//         in : start, a, b, add_s, add_co
//         out: busy, done, p, add_a, add_b
// A start accepted in IDLE yields 16 RUN cycles, one DONE cycle with
// done=1, then IDLE. p holds the last product until the next completion.
module mul16_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  mul16_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               r_state;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_p;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [CNT_W-1:0]     r_cnt;

  logic [WIDTH-1:0]     w_add_b;

  // Operand B is gated by the current multiplier LSB; with it zero the adder
  // returns hi unchanged with no carry, so RUN uses one update rule.
  always_comb begin
    w_add_b = '0;
    if (r_lo[0]) begin
      w_add_b = r_mcand;
    end
  end

  assign bus.add_a = r_hi;
  assign bus.add_b = w_add_b;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.p     = r_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_p     <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mcand <= bus.a;
            r_lo    <= bus.b;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Shift {carry, sum, lo} right by one; the carry lands in hi MSB.
          r_hi  <= {bus.add_co, bus.add_s[WIDTH-1:1]};
          r_lo  <= {bus.add_s[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_p     <= {bus.add_co, bus.add_s, r_lo[WIDTH-1:1]};
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq: self-checking bench for mul16_seq with a behavioural
// external adder, a product scoreboard and a per-cycle hi/lo model.
module tb_mul16_seq;

  logic clk;
  logic rst;

  mul16_seq_if #(.WIDTH(16)) bus ();

  // External 16-bit adder.
  assign {bus.add_co, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

  mul16_seq #(.WIDTH(16), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_err;
  logic [31:0] sb[$];
  logic [31:0] last_p;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one multiply starting in the current cycle (N). Checks every RUN
  // cycle against a bench hi/lo model, then done at N+17 and idle at N+18.
  // With inject set, start pulses (a=b=1) at N+5 and N+17 must be ignored.
  task automatic run_mul(input logic [15:0] ia, input logic [15:0] ib,
                         input logic [31:0] exp, input bit inject);
    logic [15:0] m_hi, m_lo, m_mc, m_b;
    logic [16:0] s;
    logic [31:0] got_exp;
    int          w;
    bus.a = ia;
    bus.b = ib;
    bus.start = 1'b1;
    sb.push_back(exp);
    m_hi = '0;
    m_lo = ib;
    m_mc = ia;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      m_b = m_lo[0] ? m_mc : 16'h0000;
      chk("run_busy", 32'(bus.busy), 32'd1);
      chk("run_done", 32'(bus.done), 32'd0);
      chk("add_a", 32'(bus.add_a), 32'(m_hi));
      chk("add_b", 32'(bus.add_b), 32'(m_b));
      chk("p_hold", bus.p, last_p);
      s = {1'b0, m_hi} + {1'b0, m_b};
      m_hi = s[16:1];
      m_lo = {s[0], m_lo[15:1]};
      if (inject && k == 4) begin
        bus.start = 1'b1;
        bus.a = 16'd1;
        bus.b = 16'd1;
      end else if (inject && k == 5) begin
        bus.start = 1'b0;
      end
      tick();
    end
    w = 0;
    while (bus.done !== 1'b1 && w < 4) begin
      tick();
      w++;
    end
    chk("done_latency", 32'(w), 32'd0);
    if (bus.done === 1'b1) begin
      got_exp = sb.pop_front();
      chk("product", bus.p, got_exp);
      chk("done_busy", 32'(bus.busy), 32'd1);
    end else begin
      void'(sb.pop_front());
      chk("done_timeout", 32'(bus.done), 32'd1);
    end
    if (inject) bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_p", bus.p, exp);
    last_p = exp;
  endtask

  initial begin
    int dones;
    logic [15:0] ra, rb;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    last_p = '0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_p", bus.p, 32'h0);
    chk("rst_add_a", 32'(bus.add_a), 32'd0);
    chk("rst_add_b", 32'(bus.add_b), 32'd0);
    rst = 1'b0;
    tick();

    run_mul(16'd3, 16'd5, 32'h0000000F, 1'b0);
    run_mul(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0);
    run_mul(16'h1234, 16'h0000, 32'h0, 1'b0);
    run_mul(16'h0000, 16'hABCD, 32'h0, 1'b0);
    run_mul(16'd7, 16'd9, 32'd63, 1'b1);
    run_mul(16'd100, 16'd200, 32'd20000, 1'b0);

    // Reset in the middle of a 300*400 run.
    bus.a = 16'd300;
    bus.b = 16'd400;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_p", bus.p, 32'h0);
    last_p = '0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done === 1'b1) dones++;
      tick();
    end
    chk("mid_rst_no_done", 32'(dones), 32'd0);
    run_mul(16'd2, 16'd3, 32'd6, 1'b0);

    // Reset and start together: reset wins.
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = 16'd5;
    bus.b = 16'd5;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    chk("rst_start_busy", 32'(bus.busy), 32'd0);
    chk("rst_start_p", bus.p, 32'h0);
    tick();
    chk("rst_start_busy2", 32'(bus.busy), 32'd0);
    last_p = '0;

    for (int r = 0; r < 1000; r++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_mul(ra, rb, 32'(ra) * 32'(rb), 1'b0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul16_seq.md
Name: mul16_seq

Overview:
- Sequential 16x16 unsigned shift-and-add multiplier.
- Sits directly around the team's 16-bit ripple-carry adder:
  - drives the adder's two operand inputs;
  - consumes the adder's sum and carry-out each cycle.
- Produces a 32-bit product after 16 iterations.
- The adder is instantiated outside this block and connected through the add_* ports, so the adder stays a reusable leaf.

Parameters:
- WIDTH, 16, operand width. Must equal the external adder width; only 16 is supported.
- CNT_W, 4, iteration counter width, equal to log2(WIDTH).

Ports:
- clk     in   1   rising-edge clock
- rst     in   1   synchronous reset, active-high
- start   in   1   request a multiply; sampled only in IDLE
- a       in   16  multiplicand; captured on accepted start
- b       in   16  multiplier; captured on accepted start
- busy    out  1   high in RUN and DONE states
- done    out  1   one-cycle pulse; p valid from this cycle on
- p       out  32  product register; holds until the next completion
- add_a   out  16  adder operand A = hi accumulator register
- add_b   out  16  adder operand B = mcand if lo[0]==1, else 16'h0000
- add_s   in   16  adder sum (combinational return)
- add_co  in   1   adder carry-out

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst; all state updates only on the rising edge of clk.
- Reset values:
  - state=IDLE, busy=0, done=0, p=32'h0;
  - internal hi=0, lo=0, mcand=0, cnt=0;
  - add_a=0 and add_b=0 follow from the registers.
- Internal registers: mcand[15:0], hi[15:0], lo[15:0], cnt[CNT_W-1:0].
- add_a and add_b are purely combinational from the registers. There is no register between this block and the adder; add_s and add_co are used in the same cycle.
- States:
  - IDLE: busy=0, done=0.
    - If start=1: mcand<=a, lo<=b, hi<=0, cnt<=0, go RUN.
    - Else stay in IDLE.
  - RUN: busy=1. Each cycle:
    - hi <= {add_co, add_s[15:1]};
    - lo <= {add_s[0], lo[15:1]};
    - cnt <= cnt+1.
    - When lo[0]==0, add_b=0, so add_s=hi and add_co=0. The same update equation therefore applies unchanged.
    - If cnt==15: also p <= {add_co, add_s, lo[15:1]}, i.e. the final {hi,lo}, then go DONE.
  - DONE: busy=1, done=1 for exactly one cycle, then go IDLE unconditionally.
- Latency: start accepted in cycle N gives RUN in cycles N+1..N+16, done=1 in cycle N+17, and IDLE (ready for start) in cycle N+18.
- start while busy=1 (RUN or DONE) is ignored; it is not queued.
- a and b may change freely after acceptance; only the captured values are used.
- p changes only on the final RUN edge and on reset. It keeps the previous product during a new run.
- Arithmetic is unsigned. The 32-bit product never overflows; the adder carry is folded into hi[15] every iteration.
- Reset mid-operation: the block returns to IDLE next edge, p=0, no done pulse, and the partial result is discarded.
- rst and start asserted together: rst wins.

Test Plan:
- Reset, then start with a=16'd3, b=16'd5 at cycle N -> busy=1 from N+1; done=1 only at N+17 with p=32'h0000000F; busy=0 at N+18.
- a=16'hFFFF, b=16'hFFFF -> p=32'hFFFE0001. Checks that add_co is captured on every iteration.
- a=16'h1234, b=16'h0000 -> add_b=0 in all 16 RUN cycles; p=32'h0. Then a=16'h0000, b=16'hABCD -> p=32'h0.
- Start a=16'd7, b=16'd9; pulse start again with a=1, b=1 at N+5 and N+17 -> both ignored; p=32'd63 with a single done. A start at N+18 is accepted.
- Complete 100*200 (p=32'd20000). Start 300*400, assert rst at N+8 for one cycle -> busy=0, done never pulses, p=0. A following 2*3 gives p=6 with full 17-cycle latency.
- Random a,b regression (1000 runs) against a reference a*b. Check add_a/add_b on each RUN cycle against the hi/lo[0] model.
